uart_rx: RTL and testbench

UART serial receiver that deserialises one asynchronous frame (start bit, DBIT data bits LSB first, optional parity, stop bit) from the `rx` line. Bit timing comes from the x16 oversampling tick (`BR2`) of the baud-rate generator. Each received byte is presented on a parallel output with a one-cycle done strobe. The block is the receive half of the UART and pairs with the baud-rate generator top.

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: x16 oversampled start/data/stop deserialiser.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_err.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done_tick,
`ifdef UART_RX_PARITY_EN
    output logic            parity_err,
`endif
    output logic            frame_err
);
    localparam int SW = (SB_TICK <= 16) ? 4 : 6;
    localparam int NW = $clog2(DBIT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            rx_m_q, rx_s_q;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] sh_q, sh_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(7)) begin
                        // A line back high at mid start bit is noise.
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(15)) begin
                        sh_d    = {rx_s_q, sh_q[DBIT-1:1]};
                        s_cnt_d = '0;
                        if (n_cnt_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(15)) begin
                        par_d   = rx_s_q;
                        s_cnt_d = '0;
                        state_d = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(SB_TICK - 1)) begin
                        data_d  = sh_q;
                        ferr_d  = ~rx_s_q;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^sh_q) ^ par_q;
`endif
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            rx_m_q  <= rx;
            rx_s_q  <= rx_m_q;
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_data      = data_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, corner sequences,
// random frames against a frame-level model.
module tb_uart_rx;
    localparam int BITCLK = 256;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;

    uart_rx dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
`ifdef UART_RX_PARITY_EN
        .parity_err   (parity_err),
`endif
        .frame_err    (frame_err)
    );
`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always #5 clk = ~clk;

    logic [3:0] tcnt = 4'd0;
    always @(negedge clk) begin
        tcnt   = tcnt + 4'd1;
        s_tick = (tcnt == 4'd0);
    end

    typedef struct {
        logic [7:0] d;
        bit         ferr;
        bit         perr;
    } got_t;

    got_t got_q[$];
    int   stab_err = 0;
    logic [7:0] prev_data = 8'h00;
    logic rst_recent = 1'b1;

    always @(posedge clk) rst_recent <= !reset_n;

    always @(negedge clk) begin
        if (rx_done_tick) begin
            got_q.push_back('{rx_data, frame_err, parity_err});
        end else if (rx_data != prev_data && !rst_recent) begin
            stab_err++;
        end
        prev_data = rx_data;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop,
                              input bit par, input int rst_bit);
        bit bits[$];
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(d[k]);
`ifdef UART_RX_PARITY_EN
        bits.push_back(par);
`endif
        bits.push_back(stop);
        foreach (bits[i]) begin
            rx = bits[i];
            for (int c = 0; c < BITCLK; c++) begin
                @(negedge clk);
                if (i == rst_bit + 1) begin
                    if (c == 128) reset_n = 1'b0;
                    else if (c == 129) reset_n = 1'b1;
                end
            end
        end
        rx = 1'b1;
    endtask

    task automatic expect_frame(input string name, input logic [7:0] ed,
                                input bit ef, input bit ep, input int base);
        got_t g;
        check({name, "_done_cnt"}, got_q.size() - base, 1);
        if (got_q.size() > base) begin
            g = got_q.pop_back();
            check({name, "_data"}, g.d, ed);
            check({name, "_ferr"}, g.ferr, ef);
`ifdef UART_RX_PARITY_EN
            check({name, "_perr"}, g.perr, ep);
`endif
        end
        check({name, "_rx_data_hold"}, rx_data, ed);
    endtask

    typedef struct {
        logic [7:0] d;
        bit         stop;
        bit         par;
        int         gap;
        logic [7:0] exp_d;
        bit         exp_ferr;
        bit         exp_perr;
    } vec_t;

    vec_t vecs[7];
    logic [7:0] last_d;

    initial begin
        int base;
        vecs[0] = '{8'h55, 1'b1, 1'b0, BITCLK, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 1'b0, 0,      8'hA3, 1'b0, 1'b0};
        vecs[2] = '{8'h0F, 1'b1, 1'b0, BITCLK, 8'h0F, 1'b0, 1'b0};
        vecs[3] = '{8'hC6, 1'b0, 1'b0, BITCLK, 8'hC6, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, BITCLK, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{8'h07, 1'b1, 1'b1, BITCLK, 8'h07, 1'b0, 1'b0};
        vecs[6] = '{8'h07, 1'b1, 1'b0, BITCLK, 8'h07, 1'b0, 1'b1};

        reset_n = 1'b0;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_rx_data", rx_data, 0);
        check("rst_done", rx_done_tick, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_perr", parity_err, 0);
        reset_n = 1'b1;
        idle(BITCLK);

        for (int i = 0; i < 7; i++) begin
            base = got_q.size();
            send_frame(vecs[i].d, vecs[i].stop, vecs[i].par, -1);
            expect_frame($sformatf("vec%0d", i), vecs[i].exp_d,
                         vecs[i].exp_ferr, vecs[i].exp_perr, base);
            idle(vecs[i].gap);
        end
        last_d = vecs[6].exp_d;

        base = got_q.size();
        rx = 1'b0;
        repeat (80) @(negedge clk);
        idle(3 * BITCLK);
        check("glitch_done_cnt", got_q.size() - base, 0);
        check("glitch_rx_data", rx_data, last_d);

        base = got_q.size();
        send_frame(8'hFF, 1'b1, 1'b0, 4);
        idle(BITCLK);
        check("abort_done_cnt", got_q.size() - base, 0);
        check("abort_rx_data", rx_data, 0);
        check("abort_ferr", frame_err, 0);
        base = got_q.size();
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        expect_frame("after_abort", 8'h3C, 1'b0, 1'b0, base);
        idle(BITCLK);

        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            bit stop, par;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            par  = 1'($urandom);
            base = got_q.size();
            send_frame(d, stop, par, -1);
            expect_frame($sformatf("rnd%0d", i), d, ~stop,
                         (^d) ^ par, base);
            idle($urandom_range(0, 1) * BITCLK);
        end

        check("data_stable_between_done", stab_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
